// File: rtl/fetch_stage_ctrl.sv
// Instruction fetch stage with PC register and IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage_ctrl #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int unsigned      PC_STEP   = 4,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_4_d,
  output logic            valid_d,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt,
`endif
  output logic            misalign_d
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_f_reg, pc_f_next;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] instr_d_reg, instr_d_next;
  logic [XLEN-1:0] pc_d_reg, pc_d_next;
  logic [XLEN-1:0] pc_4_d_reg, pc_4_d_next;
  logic            valid_d_reg, valid_d_next;
  logic            misalign_d_reg, misalign_d_next;
  logic            misalign_f;
  logic            capture;

  // Sequential increment wraps naturally at 2^XLEN.
  assign pc_plus    = pc_f_reg + STEP;
  assign misalign_f = |pc_f_reg[1:0];
  assign capture    = !flush_d && !stall_d;

  // Redirect takes precedence over a fetch stall.
  always_comb begin
    pc_f_next = pc_plus;
    if (pc_src) begin
      pc_f_next = pc_target;
    end else if (stall_f) begin
      pc_f_next = pc_f_reg;
    end
  end

  // Flush inserts a bubble even while decode is stalled.
  always_comb begin
    instr_d_next    = instr_d_reg;
    pc_d_next       = pc_d_reg;
    pc_4_d_next     = pc_4_d_reg;
    valid_d_next    = valid_d_reg;
    misalign_d_next = misalign_d_reg;
    if (flush_d) begin
      instr_d_next    = NOP_INSTR;
      pc_d_next       = '0;
      pc_4_d_next     = '0;
      valid_d_next    = 1'b0;
      misalign_d_next = 1'b0;
    end else if (!stall_d) begin
      instr_d_next    = imem_rdata;
      pc_d_next       = pc_f_reg;
      pc_4_d_next     = pc_plus;
      valid_d_next    = 1'b1;
      misalign_d_next = misalign_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_reg       <= RESET_PC;
      instr_d_reg    <= NOP_INSTR;
      pc_d_reg       <= '0;
      pc_4_d_reg     <= '0;
      valid_d_reg    <= 1'b0;
      misalign_d_reg <= 1'b0;
    end else begin
      pc_f_reg       <= pc_f_next;
      instr_d_reg    <= instr_d_next;
      pc_d_reg       <= pc_d_next;
      pc_4_d_reg     <= pc_4_d_next;
      valid_d_reg    <= valid_d_next;
      misalign_d_reg <= misalign_d_next;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_reg;
  logic [31:0] perf_bubble_cnt_reg;

  // Bubble cycles are any cycle in which decode is flushed or held.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_reg  <= '0;
      perf_bubble_cnt_reg <= '0;
    end else begin
      if (capture) begin
        perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
      end
      if (flush_d || stall_d) begin
        perf_bubble_cnt_reg <= perf_bubble_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = perf_fetch_cnt_reg;
  assign perf_bubble_cnt = perf_bubble_cnt_reg;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

  assign imem_addr  = pc_f_reg;
  assign pc_f       = pc_f_reg;
  assign instr_d    = instr_d_reg;
  assign pc_d       = pc_d_reg;
  assign pc_4_d     = pc_4_d_reg;
  assign valid_d    = valid_d_reg;
  assign misalign_d = misalign_d_reg;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed vector table, PC wrap
// instance, and randomized traffic against a behavioural model.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pc_src, stall_f, stall_d, flush_d;
  logic [31:0] pc_target;
  logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_4_d;
  logic        valid_d, misalign_d;

  logic        rst_w;
  logic [31:0] w_addr, w_rdata, w_pc_f, w_instr_d, w_pc_d, w_pc_4_d;
  logic        w_valid_d, w_misalign_d;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
  logic [31:0] w_perf_fetch_cnt, w_perf_bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_f(imem_addr);
  assign w_rdata    = mem_f(w_addr);

  fetch_stage_ctrl dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f),
    .instr_d(instr_d), .pc_d(pc_d), .pc_4_d(pc_4_d), .valid_d(valid_d),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .misalign_d(misalign_d)
  );

  fetch_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .pc_src(1'b0), .pc_target(32'h0),
    .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .pc_f(w_pc_f),
    .instr_d(w_instr_d), .pc_d(w_pc_d), .pc_4_d(w_pc_4_d), .valid_d(w_valid_d),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(w_perf_fetch_cnt), .perf_bubble_cnt(w_perf_bubble_cnt),
`endif
    .misalign_d(w_misalign_d)
  );

  // Behavioural model: architectural view of the fetch PC and decode slot.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fcnt, m_bcnt;
  logic        m_valid, m_mis;

  task automatic model_step();
    logic [31:0] fetched_pc;
    fetched_pc = m_pc;
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
      m_valid = 0; m_mis = 0; m_fcnt = 0; m_bcnt = 0;
    end else begin
      if (pc_src)        m_pc = pc_target;
      else if (!stall_f) m_pc = fetched_pc + 32'd4;
      if (flush_d) begin
        m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
      end else if (!stall_d) begin
        m_instr = mem_f(fetched_pc); m_pcd = fetched_pc;
        m_pc4 = fetched_pc + 32'd4; m_valid = 1; m_mis = (fetched_pc % 4) != 0;
        m_fcnt = m_fcnt + 1;
      end
      if (flush_d || stall_d) m_bcnt = m_bcnt + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pc_f"},      pc_f,       m_pc);
    chk({tag, " instr_d"},   instr_d,    m_instr);
    chk({tag, " pc_d"},      pc_d,       m_pcd);
    chk({tag, " pc_4_d"},    pc_4_d,     m_pc4);
    chk({tag, " valid_d"},   {31'b0, valid_d},    {31'b0, m_valid});
    chk({tag, " misalign"},  {31'b0, misalign_d}, {31'b0, m_mis});
`ifdef FETCH_PERF_EN
    chk({tag, " perf_fetch"},  perf_fetch_cnt,  m_fcnt);
    chk({tag, " perf_bubble"}, perf_bubble_cnt, m_bcnt);
`endif
  endtask

  typedef struct {
    logic        rst, src;
    logic [31:0] tgt;
    logic        sf, sd, fl;
    logic [31:0] e_pcf, e_pcd;
    logic        e_v, e_m;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic r, input logic s, input logic [31:0] t,
                              input logic sf, input logic sd, input logic fl,
                              input logic [31:0] pf, input logic [31:0] pd,
                              input logic v, input logic m);
    vec_t x;
    x.rst = r; x.src = s; x.tgt = t; x.sf = sf; x.sd = sd; x.fl = fl;
    x.e_pcf = pf; x.e_pcd = pd; x.e_v = v; x.e_m = m;
    return x;
  endfunction

  initial begin
    //           rst src tgt          sf sd fl   pc_f          pc_d          v  m
    tbl[0]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 0);
    tbl[1]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 0);
    tbl[2]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h4,        32'h0,        1, 0);
    tbl[3]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h8,        32'h4,        1, 0);
    tbl[4]  = mk(0, 0, 32'h0,         0, 0, 0, 32'hC,        32'h8,        1, 0);
    tbl[5]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h10,       32'hC,        1, 0);
    tbl[6]  = mk(0, 1, 32'h40,        0, 0, 1, 32'h40,       32'h0,        0, 0);
    tbl[7]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h44,       32'h40,       1, 0);
    tbl[8]  = mk(0, 1, 32'h1C,        0, 0, 1, 32'h1C,       32'h0,        0, 0);
    tbl[9]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h20,       32'h1C,       1, 0);
    tbl[10] = mk(0, 0, 32'h0,         1, 1, 0, 32'h20,       32'h1C,       1, 0);
    tbl[11] = mk(0, 0, 32'h0,         1, 1, 0, 32'h20,       32'h1C,       1, 0);
    tbl[12] = mk(0, 0, 32'h0,         1, 1, 0, 32'h20,       32'h1C,       1, 0);
    tbl[13] = mk(0, 0, 32'h0,         0, 0, 0, 32'h24,       32'h20,       1, 0);
    tbl[14] = mk(0, 1, 32'h80,        1, 1, 1, 32'h80,       32'h0,        0, 0);
    tbl[15] = mk(0, 0, 32'h0,         0, 0, 0, 32'h84,       32'h80,       1, 0);
    tbl[16] = mk(0, 1, 32'h102,       0, 0, 1, 32'h102,      32'h0,        0, 0);
    tbl[17] = mk(0, 0, 32'h0,         0, 0, 0, 32'h106,      32'h102,      1, 1);
    tbl[18] = mk(0, 0, 32'h0,         0, 0, 0, 32'h10A,      32'h106,      1, 1);
    tbl[19] = mk(1, 1, 32'h200,       1, 1, 0, 32'h0,        32'h0,        0, 0);
    tbl[20] = mk(0, 0, 32'h0,         0, 0, 0, 32'h4,        32'h0,        1, 0);

    rst = 1; rst_w = 1; pc_src = 0; pc_target = 0; stall_f = 0; stall_d = 0; flush_d = 0;
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
    m_fcnt = 0; m_bcnt = 0;

    // Directed vectors
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; pc_src = tbl[i].src; pc_target = tbl[i].tgt;
      stall_f = tbl[i].sf; stall_d = tbl[i].sd; flush_d = tbl[i].fl;
      tick();
      chk($sformatf("vec%0d pc_f", i),      pc_f,      tbl[i].e_pcf);
      chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_pcf);
      chk($sformatf("vec%0d pc_d", i),      pc_d,      tbl[i].e_pcd);
      chk($sformatf("vec%0d valid_d", i),   {31'b0, valid_d},    {31'b0, tbl[i].e_v});
      chk($sformatf("vec%0d misalign", i),  {31'b0, misalign_d}, {31'b0, tbl[i].e_m});
      chk($sformatf("vec%0d instr_d", i),   instr_d, tbl[i].e_v ? mem_f(tbl[i].e_pcd) : NOP);
      chk($sformatf("vec%0d pc_4_d", i),    pc_4_d,  tbl[i].e_v ? tbl[i].e_pcd + 32'd4 : 32'h0);
      check_model($sformatf("vec%0d", i));
      $display("vec %0d: pc_f=%h pc_d=%h instr_d=%h valid=%0b mis=%0b",
               i, pc_f, pc_d, instr_d, valid_d, misalign_d);
    end

    // Perf counters across a fresh reset plus the 3-cycle stall
`ifdef FETCH_PERF_EN
    rst = 1; pc_src = 0; stall_f = 0; stall_d = 0; flush_d = 0;
    tick();
    rst = 0;
    tick(); tick();
    stall_f = 1; stall_d = 1;
    tick(); tick(); tick();
    stall_f = 0; stall_d = 0;
    tick();
    chk("perf bubble after stall", perf_bubble_cnt, 32'd3);
    chk("perf fetch after stall",  perf_fetch_cnt,  32'd3);
    $display("perf: fetch=%0d bubble=%0d", perf_fetch_cnt, perf_bubble_cnt);
`endif

    // PC wrap on the high-reset-vector instance
    rst = 0; pc_src = 0; stall_f = 0; stall_d = 0; flush_d = 0;
    chk("wrap reset pc_f", w_pc_f, 32'hFFFF_FFFC);
    rst_w = 0;
    tick();
    chk("wrap pc_f",     w_pc_f,   32'h0);
    chk("wrap pc_d",     w_pc_d,   32'hFFFF_FFFC);
    chk("wrap pc_4_d",   w_pc_4_d, 32'h0);
    chk("wrap instr_d",  w_instr_d, mem_f(32'hFFFF_FFFC));
    chk("wrap valid_d",  {31'b0, w_valid_d}, 32'h1);
    $display("wrap: pc_f=%h pc_d=%h pc_4_d=%h", w_pc_f, w_pc_d, w_pc_4_d);
    tick();
    chk("wrap2 pc_f",    w_pc_f,   32'h4);
    chk("wrap2 pc_4_d",  w_pc_4_d, 32'h4);
    chk("wrap2 misalign", {31'b0, w_misalign_d}, 32'h0);
    $display("wrap2: pc_f=%h pc_d=%h pc_4_d=%h", w_pc_f, w_pc_d, w_pc_4_d);
    check_model("postwrap");

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      pc_src    = ($urandom_range(0, 7) == 0);
      pc_target = {$urandom_range(0, 16'hFFFF), 16'h0} | 32'($urandom_range(0, 16'hFFFF));
      stall_f   = ($urandom_range(0, 5) == 0);
      stall_d   = ($urandom_range(0, 5) == 0);
      flush_d   = ($urandom_range(0, 6) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
      $display("rnd %0d: rst=%0b src=%0b sf=%0b sd=%0b fl=%0b pc_f=%h pc_d=%h valid=%0b mis=%0b",
               i, rst, pc_src, stall_f, stall_d, flush_d, pc_f, pc_d, valid_d, misalign_d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
